prefix_seq_xix: RTL and testbench

PREFIX_SEQ_XIX -- requirements
Module: prefix_seq_xix

---
 rtl/prefix_seq_xix_pkg.sv | 29 ++
 rtl/prefix_seq_xix_xpt_counter.sv | 45 ++++
 rtl/prefix_seq_xix.sv | 106 ++++++++++
 tb/tb_prefix_seq_xix.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/prefix_seq_xix_pkg.sv
// Shared constants, state encoding and control-strobe bundle for the
// DD/FD prefix sequencer.
package prefix_seq_xix_pkg;

  localparam logic [7:0] PREFIX_DD = 8'hDD;
  localparam logic [7:0] PREFIX_FD = 8'hFD;
  localparam int         XPT_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PFX  = 2'd1,
    S_EXEC = 2'd2
  } state_e;

  // Per-cycle control strobes produced by the FSM output logic.
  typedef struct packed {
    logic take_pfx;   // prefix byte accepted (IDLE or PFX)
    logic latch_src;  // opcode accepted in PFX
    logic pass;       // non-prefix byte accepted in IDLE
    logic end_instr;  // decoder end/clear request honoured in EXEC
    logic xpt_clr;
    logic xpt_en;
  } ctl_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PREFIX_DD) || (b == PREFIX_FD);
  endfunction

endpackage

// File: rtl/prefix_seq_xix_xpt_counter.sv
// Saturating T-step counter with clear, enable and a sticky overflow flag.
// The complement output is registered alongside so it never glitches.
module xpt_counter
  import prefix_seq_xix_pkg::*;
#(
  parameter int W = XPT_W
) (
  input  logic         clock,
  input  logic         not_reset,
  input  logic         clr,
  input  logic         en,
  input  logic         ovf_clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] ncnt,
  output logic         ovf
);

  logic [W-1:0] inc;
  logic         at_max;

  assign inc    = cnt + 1'b1;
  assign at_max = (cnt == {W{1'b1}});

  // Count register: clear wins over enable; hold at all-ones.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      cnt  <= '0;
      ncnt <= '1;
    end else if (clr) begin
      cnt  <= '0;
      ncnt <= '1;
    end else if (en && !at_max) begin
      cnt  <= inc;
      ncnt <= ~inc;
    end
  end

  // Sticky overflow: set on an enabled step at max, cleared only on request.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset)                 ovf <= 1'b0;
    else if (ovf_clr)               ovf <= 1'b0;
    else if (en && !clr && at_max)  ovf <= 1'b1;
  end

endmodule

// File: rtl/prefix_seq_xix.sv
// DD/FD prefix sequencer: tracks IX/IY prefix bytes, latches the following
// opcode and runs the XIX decoder T-step counter until the decoder ends the
// instruction. All outputs except op_ready come straight from flops.
module prefix_seq_xix
  import prefix_seq_xix_pkg::*;
(
  input  logic       clock,
  input  logic       not_reset,
  input  logic [7:0] op_byte,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       step_en,
  input  logic       PR_Reset_XPT,
  input  logic       P2_Reset_XIX,
  input  logic       P2_Reset_XIY,
  output logic       not_enable,
  output logic       is_Y,
  output logic [7:0] Source,
  output logic [7:0] notSource,
  output logic [4:0] XPT,
  output logic [4:0] notXPT,
  output logic       op_pass,
  output logic       xpt_overflow
);

  state_e     state, state_nxt;
  ctl_t       ctl;
  logic [1:0] rst_sync;
  logic       run;
  logic       acc;
  logic       pfx;
  logic       rst_req;

  assign run     = rst_sync[1];
  assign acc     = op_valid && op_ready;
  assign pfx     = is_prefix(op_byte);
  assign rst_req = PR_Reset_XPT || P2_Reset_XIX || P2_Reset_XIY;

  // Reset release synchroniser: assert is immediate, release takes two edges
  // before the block will accept its first byte.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  // State register.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic; decoder requests only matter in EXEC.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (acc && pfx)  state_nxt = S_PFX;
      S_PFX:   if (acc && !pfx) state_nxt = S_EXEC;
      S_EXEC:  if (rst_req)     state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  // Output/strobe logic. op_ready depends on registers only.
  always_comb begin
    op_ready      = run && (state != S_EXEC);
    ctl           = '0;
    ctl.take_pfx  = acc && pfx;
    ctl.latch_src = acc && !pfx && (state == S_PFX);
    ctl.pass      = acc && !pfx && (state == S_IDLE);
    ctl.end_instr = (state == S_EXEC) && rst_req;
    ctl.xpt_clr   = ctl.latch_src || ctl.end_instr;
    ctl.xpt_en    = (state == S_EXEC) && step_en && !rst_req;
  end

  // Registered outputs: prefix select, opcode latch, pass pulse, enable.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      is_Y       <= 1'b0;
      Source     <= 8'h00;
      notSource  <= 8'hFF;
      op_pass    <= 1'b0;
      not_enable <= 1'b1;
    end else begin
      if (ctl.end_instr)     is_Y <= 1'b0;
      else if (ctl.take_pfx) is_Y <= (op_byte == PREFIX_FD);
      if (ctl.latch_src) begin
        Source    <= op_byte;
        notSource <= ~op_byte;
      end
      op_pass    <= ctl.pass;
      not_enable <= (state_nxt != S_EXEC);
    end
  end

  xpt_counter #(.W(XPT_W)) u_xpt (
    .clock     (clock),
    .not_reset (not_reset),
    .clr       (ctl.xpt_clr),
    .en        (ctl.xpt_en),
    .ovf_clr   (ctl.end_instr),
    .cnt       (XPT),
    .ncnt      (notXPT),
    .ovf       (xpt_overflow)
  );

endmodule

// File: tb/tb_prefix_seq_xix.sv
// Directed bench for prefix_seq_xix: inputs change 1ns after the rising edge,
// outputs are checked at that same point, away from the edge.
module tb_prefix_seq_xix;

  logic       clock = 1'b0;
  logic       not_reset;
  logic [7:0] op_byte;
  logic       op_valid;
  logic       op_ready;
  logic       step_en;
  logic       PR_Reset_XPT, P2_Reset_XIX, P2_Reset_XIY;
  logic       not_enable, is_Y, op_pass, xpt_overflow;
  logic [7:0] Source, notSource;
  logic [4:0] XPT, notXPT;

  int total = 0;
  int errs  = 0;

  always #5 clock = ~clock;

  prefix_seq_xix dut (
    .clock        (clock),
    .not_reset    (not_reset),
    .op_byte      (op_byte),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .step_en      (step_en),
    .PR_Reset_XPT (PR_Reset_XPT),
    .P2_Reset_XIX (P2_Reset_XIX),
    .P2_Reset_XIY (P2_Reset_XIY),
    .not_enable   (not_enable),
    .is_Y         (is_Y),
    .Source       (Source),
    .notSource    (notSource),
    .XPT          (XPT),
    .notXPT       (notXPT),
    .op_pass      (op_pass),
    .xpt_overflow (xpt_overflow)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    op_byte  = b;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    not_reset = 1'b0; op_byte = 8'h00; op_valid = 1'b0; step_en = 1'b0;
    PR_Reset_XPT = 1'b0; P2_Reset_XIX = 1'b0; P2_Reset_XIY = 1'b0;
    #22;
    total++; if ({XPT, notXPT} !== {5'h00, 5'h1F}) begin errs++; $display("FAIL reset_xpt: got %h/%h want 00/1f", XPT, notXPT); end
    total++; if ({Source, notSource} !== 16'h00FF) begin errs++; $display("FAIL reset_src: got %h/%h want 00/ff", Source, notSource); end
    total++; if ({is_Y, not_enable, op_pass, xpt_overflow} !== 4'b0100) begin errs++; $display("FAIL reset_flags: got %b want 0100", {is_Y, not_enable, op_pass, xpt_overflow}); end
    not_reset = 1'b1;
    step(); step(); step();
    total++; if (op_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_dd_opcode();
    send(8'hDD);
    send(8'h21);
    total++; if ({is_Y, Source, notSource} !== {1'b0, 8'h21, 8'hDE}) begin errs++; $display("FAIL dd_src: got %b %h %h want 0 21 de", is_Y, Source, notSource); end
    total++; if ({XPT, notXPT, not_enable, op_ready} !== {5'd0, 5'h1F, 1'b0, 1'b0}) begin errs++; $display("FAIL dd_exec: got %h %h %b %b want 00 1f 0 0", XPT, notXPT, not_enable, op_ready); end
    PR_Reset_XPT = 1'b1; step(); PR_Reset_XPT = 1'b0;
    total++; if ({not_enable, op_ready} !== 2'b11) begin errs++; $display("FAIL dd_end: got %b want 11", {not_enable, op_ready}); end
  endtask

  task automatic test_last_prefix_wins();
    send(8'hFD); send(8'hDD); send(8'hFD);
    total++; if ({is_Y, not_enable, op_ready} !== 3'b111) begin errs++; $display("FAIL pfx_chain: got %b want 111", {is_Y, not_enable, op_ready}); end
    send(8'h7E);
    total++; if ({is_Y, Source, not_enable} !== {1'b1, 8'h7E, 1'b0}) begin errs++; $display("FAIL pfx_exec: got %b %h %b want 1 7e 0", is_Y, Source, not_enable); end
  endtask

  task automatic test_step_and_reset();
    logic [3:0] pat;
    logic [4:0] exp_x [4];
    pat = 4'b1011;  // applied LSB first: 1,1,0,1
    exp_x[0] = 5'd1; exp_x[1] = 5'd2; exp_x[2] = 5'd2; exp_x[3] = 5'd3;
    for (int i = 0; i < 4; i++) begin
      step_en = pat[i];
      step();
      total++; if ({XPT, notXPT} !== {exp_x[i], ~exp_x[i]}) begin errs++; $display("FAIL step_%0d: got %h/%h want %h/%h", i, XPT, notXPT, exp_x[i], ~exp_x[i]); end
    end
    step_en = 1'b1; PR_Reset_XPT = 1'b1;
    step();
    step_en = 1'b0; PR_Reset_XPT = 1'b0;
    total++; if ({XPT, not_enable, op_ready, is_Y} !== {5'd0, 1'b1, 1'b1, 1'b0}) begin errs++; $display("FAIL step_end: got %h %b %b %b want 00 1 1 0", XPT, not_enable, op_ready, is_Y); end
  endtask

  task automatic test_pass();
    send(8'h3E);
    total++; if ({op_pass, not_enable, op_ready, Source} !== {3'b111, 8'h7E}) begin errs++; $display("FAIL pass_pulse: got %b %b %b %h want 1 1 1 7e", op_pass, not_enable, op_ready, Source); end
    step();
    total++; if ({op_pass, not_enable, is_Y} !== 3'b010) begin errs++; $display("FAIL pass_end: got %b want 010", {op_pass, not_enable, is_Y}); end
  endtask

  task automatic test_overflow();
    // Decoder clear requests are ignored outside EXEC.
    P2_Reset_XIX = 1'b1;
    send(8'hDD);
    send(8'h10);
    P2_Reset_XIX = 1'b0;
    total++; if ({not_enable, Source} !== {1'b0, 8'h10}) begin errs++; $display("FAIL ovf_enter: got %b %h want 0 10", not_enable, Source); end
    step_en = 1'b1;
    for (int i = 0; i < 31; i++) step();
    total++; if ({XPT, xpt_overflow} !== {5'd31, 1'b0}) begin errs++; $display("FAIL ovf_31: got %h %b want 1f 0", XPT, xpt_overflow); end
    for (int i = 0; i < 3; i++) step();
    total++; if ({XPT, notXPT, xpt_overflow} !== {5'd31, 5'd0, 1'b1}) begin errs++; $display("FAIL ovf_sat: got %h %h %b want 1f 00 1", XPT, notXPT, xpt_overflow); end
    step_en = 1'b0; P2_Reset_XIY = 1'b1;
    step();
    P2_Reset_XIY = 1'b0;
    total++; if ({xpt_overflow, not_enable, XPT} !== {1'b0, 1'b1, 5'd0}) begin errs++; $display("FAIL ovf_clr: got %b %b %h want 0 1 00", xpt_overflow, not_enable, XPT); end
  endtask

  task automatic test_async_reset();
    send(8'hFD);
    send(8'h55);
    step_en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    step_en = 1'b0;
    total++; if (XPT !== 5'd7) begin errs++; $display("FAIL ar_pre: got %h want 07", XPT); end
    #2 not_reset = 1'b0;
    #1;
    total++; if ({XPT, notXPT, Source, notSource} !== {5'd0, 5'h1F, 8'h00, 8'hFF}) begin errs++; $display("FAIL ar_data: got %h %h %h %h want 00 1f 00 ff", XPT, notXPT, Source, notSource); end
    total++; if ({is_Y, not_enable, op_pass, xpt_overflow} !== 4'b0100) begin errs++; $display("FAIL ar_flags: got %b want 0100", {is_Y, not_enable, op_pass, xpt_overflow}); end
    // Release with an FD offered continuously: it must not land before edge 3.
    op_byte = 8'hFD; op_valid = 1'b1;
    #2 not_reset = 1'b1;
    step();
    total++; if ({is_Y, op_ready} !== 2'b00) begin errs++; $display("FAIL ar_sync1: got %b want 00", {is_Y, op_ready}); end
    step();
    total++; if ({is_Y, op_ready} !== 2'b01) begin errs++; $display("FAIL ar_sync2: got %b want 01", {is_Y, op_ready}); end
    step();
    op_valid = 1'b0;
    total++; if (is_Y !== 1'b1) begin errs++; $display("FAIL ar_sync3: got %b want 1", is_Y); end
  endtask

  initial begin
    test_reset();
    test_dd_opcode();
    test_last_prefix_wins();
    test_step_and_reset();
    test_pass();
    test_overflow();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
